// File: rtl/div_job_sequencer.sv
// Issues tagged jobs to a fixed-latency divider and returns results in order through a credit-protected FIFO.
// Optional feature macro DIV_SEQ_ZERO_GUARD_EN: divide-by-zero jobs return a saturated quotient and set div_zero.
module div_job_sequencer #(
  parameter int unsigned LATENCY      = 36,
  parameter int unsigned TAG_W        = 8,
  parameter int unsigned RESULT_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_job_tvalid,
  output logic                          s_job_tready,
  input  logic [31:0]                   s_job_dividend,
  input  logic [31:0]                   s_job_divisor,
  input  logic [TAG_W-1:0]              s_job_tag,
  output logic [31:0]                   m_axis_dividend_tdata,
  output logic                          m_axis_dividend_tvalid,
  output logic [31:0]                   m_axis_divisor_tdata,
  output logic                          m_axis_divisor_tvalid,
  input  logic [63:0]                   div_dout_tdata,
  output logic                          m_res_tvalid,
  input  logic                          m_res_tready,
  output logic [31:0]                   m_res_quotient,
  output logic [31:0]                   m_res_frac,
  output logic [TAG_W-1:0]              m_res_tag,
  output logic                          m_res_div_zero,
  output logic [$clog2(RESULT_DEPTH):0] inflight
);
  localparam int unsigned AW = $clog2(RESULT_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic             w_accept, w_capture, w_pop;
  logic [CW-1:0]    w_inflight_nxt, w_count_nxt;
  logic [CW:0]      w_credit_used;
  logic [31:0]      w_issue_divisor, w_cap_quot, w_cap_frac;

  logic             r_tready;
  logic [CW-1:0]    r_inflight, r_count;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [31:0]      r_dividend, r_divisor;
  logic             r_issue_valid;
  logic [LATENCY:0] r_pv;
  logic [TAG_W-1:0] r_ptag [LATENCY+1];
  logic [31:0]      r_mq   [RESULT_DEPTH];
  logic [31:0]      r_mf   [RESULT_DEPTH];
  logic [TAG_W-1:0] r_mt   [RESULT_DEPTH];

  assign w_accept  = s_job_tvalid & r_tready;
  assign w_capture = r_pv[LATENCY];
  assign w_pop     = m_res_tvalid & m_res_tready;

  // A capture moves a job from inflight to the FIFO, so the credit sum only moves on accept/pop.
  always_comb begin
    w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_capture);
    w_count_nxt    = r_count + CW'(w_capture) - CW'(w_pop);
    w_credit_used  = {1'b0, w_inflight_nxt} + {1'b0, w_count_nxt};
  end

`ifdef DIV_SEQ_ZERO_GUARD_EN
  logic             w_job_zero;
  logic [LATENCY:0] r_pz, r_pn;
  logic             r_mz [RESULT_DEPTH];

  assign w_job_zero      = (s_job_divisor == '0);
  assign w_issue_divisor = w_job_zero ? 32'd1 : s_job_divisor;

  always_comb begin
    w_cap_quot = div_dout_tdata[63:32];
    w_cap_frac = div_dout_tdata[31:0];
    if (r_pz[LATENCY]) begin
      w_cap_quot = r_pn[LATENCY] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      w_cap_frac = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pz <= '0;
      r_pn <= '0;
      for (int unsigned i = 0; i < RESULT_DEPTH; i++) r_mz[i] <= 1'b0;
    end else begin
      r_pz <= {r_pz[LATENCY-1:0], w_job_zero};
      r_pn <= {r_pn[LATENCY-1:0], s_job_dividend[31]};
      if (w_capture) r_mz[r_wptr] <= r_pz[LATENCY];
    end
  end

  assign m_res_div_zero = r_mz[r_rptr];
`else
  assign w_issue_divisor = s_job_divisor;
  assign w_cap_quot      = div_dout_tdata[63:32];
  assign w_cap_frac      = div_dout_tdata[31:0];
  assign m_res_div_zero  = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tready      <= 1'b0;
      r_inflight    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_issue_valid <= 1'b0;
      r_pv          <= '0;
      for (int unsigned i = 0; i < RESULT_DEPTH; i++) begin
        r_mq[i] <= '0;
        r_mf[i] <= '0;
        r_mt[i] <= '0;
      end
    end else begin
      r_tready      <= (w_credit_used < (CW+1)'(RESULT_DEPTH));
      r_inflight    <= w_inflight_nxt;
      r_count       <= w_count_nxt;
      r_issue_valid <= w_accept;
      if (w_accept) begin
        r_dividend <= s_job_dividend;
        r_divisor  <= w_issue_divisor;
      end
      r_pv <= {r_pv[LATENCY-1:0], w_accept};
      if (w_capture) begin
        r_mq[r_wptr] <= w_cap_quot;
        r_mf[r_wptr] <= w_cap_frac;
        r_mt[r_wptr] <= r_ptag[LATENCY];
        r_wptr       <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
    end
  end

  // Tags only matter where the matching valid bit is set, so this shift needs no reset.
  always_ff @(posedge aclk) begin
    r_ptag[0] <= s_job_tag;
    for (int unsigned i = 1; i <= LATENCY; i++) r_ptag[i] <= r_ptag[i-1];
  end

  assign s_job_tready           = r_tready;
  assign m_axis_dividend_tdata  = r_dividend;
  assign m_axis_dividend_tvalid = r_issue_valid;
  assign m_axis_divisor_tdata   = r_divisor;
  assign m_axis_divisor_tvalid  = r_issue_valid;
  assign m_res_tvalid           = (r_count != '0);
  assign m_res_quotient         = r_mq[r_rptr];
  assign m_res_frac             = r_mf[r_rptr];
  assign m_res_tag              = r_mt[r_rptr];
  assign inflight               = r_inflight;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Directed and randomised bench for div_job_sequencer with a behavioural fixed-latency divider.
// Honours DIV_SEQ_ZERO_GUARD_EN for the divide-by-zero expectations.
module tb_div_job_sequencer;
  localparam int unsigned LAT   = 36;
  localparam int unsigned TW    = 8;
  localparam int unsigned DEPTH = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_job_tvalid, s_job_tready;
  logic [31:0]   s_job_dividend, s_job_divisor;
  logic [TW-1:0] s_job_tag;
  logic [31:0]   m_axis_dividend_tdata, m_axis_divisor_tdata;
  logic          m_axis_dividend_tvalid, m_axis_divisor_tvalid;
  logic [63:0]   div_dout_tdata;
  logic          m_res_tvalid, m_res_tready;
  logic [31:0]   m_res_quotient, m_res_frac;
  logic [TW-1:0] m_res_tag;
  logic          m_res_div_zero;
  logic [$clog2(DEPTH):0] inflight;

  always #5 aclk = ~aclk;

  div_job_sequencer #(.LATENCY(LAT), .TAG_W(TW), .RESULT_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_job_tvalid(s_job_tvalid), .s_job_tready(s_job_tready),
    .s_job_dividend(s_job_dividend), .s_job_divisor(s_job_divisor), .s_job_tag(s_job_tag),
    .m_axis_dividend_tdata(m_axis_dividend_tdata), .m_axis_dividend_tvalid(m_axis_dividend_tvalid),
    .m_axis_divisor_tdata(m_axis_divisor_tdata), .m_axis_divisor_tvalid(m_axis_divisor_tvalid),
    .div_dout_tdata(div_dout_tdata),
    .m_res_tvalid(m_res_tvalid), .m_res_tready(m_res_tready),
    .m_res_quotient(m_res_quotient), .m_res_frac(m_res_frac), .m_res_tag(m_res_tag),
    .m_res_div_zero(m_res_div_zero), .inflight(inflight)
  );

  // Divider model: quotient/remainder, divide-by-zero yields {all ones, dividend}.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sd, q, r;
    sa = a; sd = b;
    if (b == '0) return {32'hFFFF_FFFF, a};
    q = sa / sd;
    r = sa % sd;
    return {q, r};
  endfunction

  logic [63:0] dpipe [LAT];
  always @(posedge aclk) begin
    dpipe[0] <= m_axis_dividend_tvalid ? div_model(m_axis_dividend_tdata, m_axis_divisor_tdata)
                                       : 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_dout_tdata = dpipe[LAT-1];

  typedef struct packed {
    logic [31:0]   q;
    logic [31:0]   f;
    logic [TW-1:0] t;
    logic          z;
  } exp_t;

  function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    exp_t e;
    logic [63:0] raw;
    e.t = t;
    e.z = 1'b0;
`ifdef DIV_SEQ_ZERO_GUARD_EN
    if (b == '0) begin
      e.q = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.f = '0;
      e.z = 1'b1;
      return e;
    end
`endif
    raw = div_model(a, b);
    e.q = raw[63:32];
    e.f = raw[31:0];
    return e;
  endfunction

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned acc_cnt = 0, pop_cnt = 0, max_out = 0;
  exp_t        sb[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_qf;
  logic [TW-1:0] prev_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor/scoreboard: samples on the falling edge, away from input changes.
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_res_tvalid, 1);
        check("hold_qf", {m_res_quotient, m_res_frac}, prev_qf);
        check("hold_tag", m_res_tag, prev_tag);
      end
      if (s_job_tvalid && s_job_tready) begin
        sb.push_back(expect_of(s_job_dividend, s_job_divisor, s_job_tag));
        acc_cnt++;
      end
      if (m_res_tvalid && m_res_tready) begin
        if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("res_quot", m_res_quotient, e.q);
          check("res_frac", m_res_frac, e.f);
          check("res_tag", m_res_tag, e.t);
          check("res_zero", m_res_div_zero, e.z);
        end
        pop_cnt++;
      end
      if (sb.size() > max_out) max_out = sb.size();
      prev_stall = m_res_tvalid && !m_res_tready;
      prev_qf    = {m_res_quotient, m_res_frac};
      prev_tag   = m_res_tag;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    logic ok;
    ok = 1'b0;
    s_job_tvalid = 1'b1; s_job_dividend = a; s_job_divisor = b; s_job_tag = t;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      ok = s_job_tready;
      tick();
    end
    s_job_tvalid = 1'b0;
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic wait_res(output int unsigned n);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!m_res_tvalid && n < 400);
    if (!m_res_tvalid) check("res_timeout", m_res_tvalid, 1);
  endtask

  task automatic pop_one();
    tick();
    m_res_tready = 1'b1;
    tick();
    m_res_tready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, s_job_tready, 0);
    check({tag, "_resvalid"}, m_res_tvalid, 0);
    check({tag, "_dvalid"}, {m_axis_dividend_tvalid, m_axis_divisor_tvalid}, 0);
    check({tag, "_ddata"}, {m_axis_dividend_tdata, m_axis_divisor_tdata}, 0);
    check({tag, "_res"}, {m_res_quotient, m_res_frac}, 0);
    check({tag, "_tagz"}, {m_res_tag, m_res_div_zero}, 0);
    check({tag, "_inflight"}, inflight, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int unsigned n, base, pbase, j, seen;
    logic [31:0] a, b;

    aresetn = 1'b0; s_job_tvalid = 1'b0; s_job_dividend = '0; s_job_divisor = '0;
    s_job_tag = '0; m_res_tready = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    check_all_zero("reset");
    tick();
    aresetn = 1'b1;
    tick();
    @(negedge aclk);
    check("reset_release_tready", s_job_tready, 1);
    tick();

    // 100/7 latency and issue behaviour
    send(32'd100, 32'd7, 8'h11);
    @(negedge aclk);
    check("t1_dvalid", {m_axis_dividend_tvalid, m_axis_divisor_tvalid}, 2'b11);
    check("t1_ddata", {m_axis_dividend_tdata, m_axis_divisor_tdata}, {32'd100, 32'd7});
    check("t1_inflight", inflight, 1);
    @(negedge aclk);
    check("t1_dvalid_drop", {m_axis_dividend_tvalid, m_axis_divisor_tvalid}, 2'b00);
    check("t1_ddata_hold", m_axis_dividend_tdata, 32'd100);
    wait_res(n);
    check("t1_latency", n + 2, LAT + 2);
    check("t1_quot", m_res_quotient, 32'd14);
    check("t1_tag", m_res_tag, 8'h11);
    check("t1_inflight_done", inflight, 0);
    pop_one();

    // signed truncation toward zero
    send(-32'sd100, 32'd7, 8'h22);
    send(32'd7, -32'sd100, 8'h23);
    wait_res(n);
    check("t2_neg_quot", m_res_quotient, 32'hFFFF_FFF2);
    check("t2_neg_tag", m_res_tag, 8'h22);
    pop_one();
    wait_res(n);
    check("t2_small_quot", m_res_quotient, 32'd0);
    check("t2_small_tag", m_res_tag, 8'h23);
    pop_one();
    repeat (3) tick();

    // 12 back-to-back jobs against a stalled result port
    base = acc_cnt; pbase = pop_cnt;
    for (int c = 0; c < 30; c++) begin
      j = acc_cnt - base;
      s_job_tvalid = (j < 12);
      s_job_dividend = 32'(1000 * (j + 1)); s_job_divisor = 32'(j + 3); s_job_tag = 8'(8'h30 + j);
      tick();
    end
    @(negedge aclk);
    check("t3_accepted", acc_cnt - base, 8);
    check("t3_tready_low", s_job_tready, 0);
    check("t3_inflight", inflight, DEPTH);
    tick();
    m_res_tready = 1'b1;
    for (int c = 0; c < 400 && (acc_cnt - base) < 12; c++) begin
      j = acc_cnt - base;
      s_job_dividend = 32'(1000 * (j + 1)); s_job_divisor = 32'(j + 3); s_job_tag = 8'(8'h30 + j);
      tick();
    end
    s_job_tvalid = 1'b0;
    for (int c = 0; c < 400 && (pop_cnt - pbase) < 12; c++) tick();
    repeat (5) tick();
    @(negedge aclk);
    check("t3_accepted_all", acc_cnt - base, 12);
    check("t3_returned_all", pop_cnt - pbase, 12);
    check("t3_drained", m_res_tvalid, 0);
    tick();
    m_res_tready = 1'b0;

    // divide by zero
    send(32'd5, 32'd0, 8'h41);
    @(negedge aclk);
`ifdef DIV_SEQ_ZERO_GUARD_EN
    check("t4_issue_divisor", m_axis_divisor_tdata, 32'd1);
    wait_res(n);
    check("t4_pos_quot", m_res_quotient, 32'h7FFF_FFFF);
    check("t4_pos_frac", m_res_frac, 32'd0);
    check("t4_pos_zero", m_res_div_zero, 1);
    pop_one();
    send(-32'sd5, 32'd0, 8'h42);
    wait_res(n);
    check("t4_neg_quot", m_res_quotient, 32'h8000_0000);
    check("t4_neg_zero", m_res_div_zero, 1);
    check("t4_neg_tag", m_res_tag, 8'h42);
`else
    check("t4_issue_divisor", m_axis_divisor_tdata, 32'd0);
    wait_res(n);
    check("t4_raw_quot", m_res_quotient, 32'hFFFF_FFFF);
    check("t4_raw_frac", m_res_frac, 32'd5);
    check("t4_raw_zero", m_res_div_zero, 0);
`endif
    pop_one();
    repeat (3) tick();

    // reset with jobs in flight
    m_res_tready = 1'b1;
    send(32'd11, 32'd2, 8'h51);
    send(32'd12, 32'd3, 8'h52);
    send(32'd13, 32'd4, 8'h53);
    repeat (10) tick();
    aresetn = 1'b0;
    tick();
    tick();
    @(negedge aclk);
    check_all_zero("t5_reset");
    tick();
    aresetn = 1'b1;
    tick();
    @(negedge aclk);
    check("t5_tready_after", s_job_tready, 1);
    seen = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(negedge aclk);
      if (m_res_tvalid) seen++;
    end
    check("t5_no_results", seen, 0);
    check("t5_inflight", inflight, 0);
    tick();

    // random traffic, 1000 jobs
    base = acc_cnt; pbase = pop_cnt;
    for (int c = 0; c < 20000 && (acc_cnt - base) < 1000; c++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        b = $urandom_range(1, 50);
        if ($urandom_range(0, 1) == 1) b = -b;
      end else b = $urandom;
      if (b == '0) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      s_job_tvalid = ($urandom_range(0, 3) != 0);
      s_job_dividend = a; s_job_divisor = b; s_job_tag = 8'(acc_cnt);
      m_res_tready = ($urandom_range(0, 2) != 0);
      tick();
    end
    s_job_tvalid = 1'b0;
    m_res_tready = 1'b1;
    for (int c = 0; c < 500 && (pop_cnt - pbase) < 1000; c++) tick();
    @(negedge aclk);
    check("t6_accepted", acc_cnt - base, 1000);
    check("t6_returned", pop_cnt - pbase, 1000);
    check("max_outstanding_ok", max_out <= DEPTH, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
